// File: rtl/hwpf_stride_req_arb.sv
// Round-robin arbiter that funnels the stride prefetch engines into one HPDcache
// request port and routes cache responses back to the issuing engine by tid.
package hwpf_stride_req_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  tid;
  } hwpf_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tid;
  } hwpf_rsp_t;
endpackage

module hwpf_stride_req_arb
  import hwpf_stride_req_arb_pkg::*;
#(
  parameter int unsigned NUM_HW_PREFETCH = 4,
  parameter type         hpdcache_req_t  = hwpf_req_t,
  parameter type         hpdcache_rsp_t  = hwpf_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_HW_PREFETCH-1:0] hwpf_req_valid_i,
  output logic [NUM_HW_PREFETCH-1:0] hwpf_req_ready_o,
  input  hpdcache_req_t              hwpf_req_i [NUM_HW_PREFETCH],
  output logic [NUM_HW_PREFETCH-1:0] hwpf_rsp_valid_o,
  output hpdcache_rsp_t              hwpf_rsp_o [NUM_HW_PREFETCH],
  output logic                       hpdcache_req_valid_o,
  input  logic                       hpdcache_req_ready_i,
  output hpdcache_req_t              hpdcache_req_o,
  input  logic                       hpdcache_rsp_valid_i,
  input  hpdcache_rsp_t              hpdcache_rsp_i,
  output logic                       bad_tid_o
);

  localparam int unsigned TID_WIDTH = (NUM_HW_PREFETCH > 1) ? $clog2(NUM_HW_PREFETCH) : 1;

  logic                       buf_valid_q;
  hpdcache_req_t              buf_req_q;
  logic [TID_WIDTH-1:0]       rr_ptr_q;
  logic [NUM_HW_PREFETCH-1:0] rsp_valid_q;
  hpdcache_rsp_t              rsp_q;
  logic                       bad_tid_q;

  logic                       buf_free_s;
  logic                       any_req_s;
  logic                       grant_s;
  logic [TID_WIDTH-1:0]       cand_s;
  logic [TID_WIDTH-1:0]       grant_idx_s;
  logic [TID_WIDTH-1:0]       next_ptr_s;
  logic [TID_WIDTH-1:0]       rsp_tid_s;
  logic                       tid_ok_s;
  hpdcache_req_t              load_req_s;

  // The buffer may refill in the same cycle the cache drains it.
  assign buf_free_s = !buf_valid_q || hpdcache_req_ready_i;

  // Scan engines starting at rr_ptr_q; the first requester found wins.
  always_comb begin
    any_req_s   = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int unsigned i = 0; i < NUM_HW_PREFETCH; i++) begin
      cand_s      = TID_WIDTH'((32'(rr_ptr_q) + i) % NUM_HW_PREFETCH);
      grant_idx_s = (!any_req_s && hwpf_req_valid_i[cand_s]) ? cand_s : grant_idx_s;
      any_req_s   = any_req_s | hwpf_req_valid_i[cand_s];
    end
  end

  // Grant, tid stamping with the engine index, and the pointer advance.
  always_comb begin
    grant_s          = any_req_s && buf_free_s;
    hwpf_req_ready_o = grant_s ? (NUM_HW_PREFETCH'(1'b1) << grant_idx_s) : '0;
    load_req_s       = hwpf_req_i[grant_idx_s];
    load_req_s.tid   = '0;
    load_req_s.tid[TID_WIDTH-1:0] = grant_idx_s;
    next_ptr_s = (grant_idx_s == TID_WIDTH'(NUM_HW_PREFETCH - 1)) ? '0
                                                                  : grant_idx_s + TID_WIDTH'(1);
  end

  // One-entry output buffer and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_valid_q <= 1'b0;
      buf_req_q   <= '0;
      rr_ptr_q    <= '0;
    end else if (grant_s) begin
      buf_valid_q <= 1'b1;
      buf_req_q   <= load_req_s;
      rr_ptr_q    <= next_ptr_s;
    end else if (hpdcache_req_ready_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign rsp_tid_s = hpdcache_rsp_i.tid[TID_WIDTH-1:0];
  assign tid_ok_s  = 32'(hpdcache_rsp_i.tid) < NUM_HW_PREFETCH;

  // Response stage: one-cycle valid pulse to the owning engine; out-of-range tids are dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rsp_q       <= '0;
      bad_tid_q   <= 1'b0;
    end else begin
      rsp_valid_q <= (hpdcache_rsp_valid_i && tid_ok_s) ? (NUM_HW_PREFETCH'(1'b1) << rsp_tid_s)
                                                        : '0;
      if (hpdcache_rsp_valid_i) begin
        rsp_q <= hpdcache_rsp_i;
      end
      if (hpdcache_rsp_valid_i && !tid_ok_s) begin
        bad_tid_q <= 1'b1;
      end
    end
  end

  // The same response payload is broadcast; only the valid is per engine.
  always_comb begin
    for (int unsigned e = 0; e < NUM_HW_PREFETCH; e++) begin
      hwpf_rsp_o[e] = rsp_q;
    end
  end

  assign hwpf_rsp_valid_o     = rsp_valid_q;
  assign hpdcache_req_valid_o = buf_valid_q;
  assign hpdcache_req_o       = buf_req_q;
  assign bad_tid_o            = bad_tid_q;

endmodule

// File: tb/tb_hwpf_stride_req_arb.sv
// Bench for hwpf_stride_req_arb: directed vector table, hand sequences and a
// randomized run against a cycle-level reference model.
module tb_hwpf_stride_req_arb;
  import hwpf_stride_req_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;

  // N = 4 instance
  logic [3:0]  vld;
  logic [3:0]  rdy_o;
  hwpf_req_t   req [4];
  logic [3:0]  rspv_o;
  hwpf_rsp_t   rsp_o [4];
  logic        c_valid;
  logic        c_ready;
  hwpf_req_t   c_req;
  logic        c_rsp_valid;
  hwpf_rsp_t   c_rsp;
  logic        bad;

  // N = 3 instance, used for the out-of-range tid case
  logic [2:0]  vld3;
  logic [2:0]  rdy3_o;
  hwpf_req_t   req3 [3];
  logic [2:0]  rspv3_o;
  hwpf_rsp_t   rsp3_o [3];
  logic        c3_valid;
  hwpf_req_t   c3_req;
  logic        c3_rsp_valid;
  hwpf_rsp_t   c3_rsp;
  logic        bad3;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_vld;
  hwpf_req_t   m_req;
  int          m_ptr;
  logic [3:0]  m_rspv;
  hwpf_rsp_t   m_rsp;
  bit          m_bad;

  always #5 clk_i = ~clk_i;

  hwpf_stride_req_arb #(.NUM_HW_PREFETCH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hwpf_req_valid_i(vld), .hwpf_req_ready_o(rdy_o), .hwpf_req_i(req),
    .hwpf_rsp_valid_o(rspv_o), .hwpf_rsp_o(rsp_o),
    .hpdcache_req_valid_o(c_valid), .hpdcache_req_ready_i(c_ready), .hpdcache_req_o(c_req),
    .hpdcache_rsp_valid_i(c_rsp_valid), .hpdcache_rsp_i(c_rsp), .bad_tid_o(bad)
  );

  hwpf_stride_req_arb #(.NUM_HW_PREFETCH(3)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .hwpf_req_valid_i(vld3), .hwpf_req_ready_o(rdy3_o), .hwpf_req_i(req3),
    .hwpf_rsp_valid_o(rspv3_o), .hwpf_rsp_o(rsp3_o),
    .hpdcache_req_valid_o(c3_valid), .hpdcache_req_ready_i(1'b1), .hpdcache_req_o(c3_req),
    .hpdcache_rsp_valid_i(c3_rsp_valid), .hpdcache_rsp_i(c3_rsp), .bad_tid_o(bad3)
  );

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_tid;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld  = 1'b0;
    m_req  = '0;
    m_ptr  = 0;
    m_rspv = 4'b0;
    m_rsp  = '0;
    m_bad  = 1'b0;
  endtask

  task automatic drive(input logic [3:0] v, input logic r);
    vld     = v;
    c_ready = r;
    for (int e = 0; e < 4; e++) begin
      req[e].addr = $urandom;
      req[e].tid  = 8'($urandom);
    end
  endtask

  // Check ready, clock once, advance the model, then check registered outputs.
  task automatic step();
    int         g;
    logic       free;
    logic [3:0] exp_rdy;
    #1;
    free    = !m_vld || c_ready;
    g       = pick(vld, m_ptr);
    exp_rdy = (free && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("ready_o", 64'(rdy_o), 64'(exp_rdy));
    @(posedge clk_i);
    if (free && g >= 0) begin
      m_req     = req[g];
      m_req.tid = 8'(g);
      m_vld     = 1'b1;
      m_ptr     = (g + 1) % 4;
    end else if (c_ready) begin
      m_vld = 1'b0;
    end
    m_rspv = (c_rsp_valid && c_rsp.tid < 4) ? 4'(1 << c_rsp.tid) : 4'b0;
    if (c_rsp_valid) m_rsp = c_rsp;
    if (c_rsp_valid && c_rsp.tid >= 4) m_bad = 1'b1;
    #1;
    chk("req_valid", 64'(c_valid), 64'(m_vld));
    chk("req_o", 64'(c_req), 64'(m_req));
    chk("rsp_valid", 64'(rspv_o), 64'(m_rspv));
    chk("rsp_o0", 64'(rsp_o[0]), 64'(m_rsp));
    chk("rsp_o3", 64'(rsp_o[3]), 64'(m_rsp));
    chk("bad_tid", 64'(bad), 64'(m_bad));
  endtask

  task automatic do_reset();
    rst_ni       = 1'b0;
    vld          = 4'b0;
    c_ready      = 1'b1;
    c_rsp_valid  = 1'b0;
    c_rsp        = '0;
    c3_rsp_valid = 1'b0;
    c3_rsp       = '0;
    #1;
    chk("rst_req_valid", 64'(c_valid), 64'd0);
    chk("rst_rsp_valid", 64'(rspv_o), 64'd0);
    chk("rst_bad", 64'(bad), 64'd0);
    chk("rst_req_o", 64'(c_req), 64'd0);
    chk("rst_bad3", 64'(bad3), 64'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    vld = 4'b0; c_ready = 1'b1; c_rsp_valid = 1'b0; c_rsp = '0;
    vld3 = 3'b0; c3_rsp_valid = 1'b0; c3_rsp = '0;
    for (int e = 0; e < 4; e++) req[e] = '0;
    for (int e = 0; e < 3; e++) req3[e] = '0;
    #3;

    // contention: rotate 0,1,2,3,0,1
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'd2});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'd3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'd1});
    // single engine 2, one request per cycle
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd2});
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd2});
    tbl.push_back('{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'd2});
    // backpressure on engine 1's request, then refill with engine 2 on release
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'd2});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'd0});

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        drive(tbl[i].vld, tbl[i].rdy);
        #1;
        chk($sformatf("tbl%0d_ready", i), 64'(rdy_o), 64'(tbl[i].exp_rdy));
        step();
        chk($sformatf("tbl%0d_valid", i), 64'(c_valid), 64'(tbl[i].exp_v));
        if (tbl[i].exp_v) chk($sformatf("tbl%0d_tid", i), 64'(c_req.tid), 64'(tbl[i].exp_tid));
      end
    end

    // response routing: tid 3 then tid 0 on consecutive cycles
    do_reset();
    drive(4'b0000, 1'b1);
    c_rsp_valid = 1'b1; c_rsp.data = $urandom; c_rsp.tid = 8'd3;
    step();
    chk("route_t1", 64'(rspv_o), 64'(4'b1000));
    c_rsp.data = $urandom; c_rsp.tid = 8'd0;
    step();
    chk("route_t2", 64'(rspv_o), 64'(4'b0001));
    c_rsp_valid = 1'b0;
    step();
    chk("route_idle", 64'(rspv_o), 64'(4'b0000));

    // out-of-range tid on the N = 3 instance
    c3_rsp_valid = 1'b1; c3_rsp.data = $urandom; c3_rsp.tid = 8'd3;
    step();
    chk("bad3_drop", 64'(rspv3_o), 64'd0);
    chk("bad3_set", 64'(bad3), 64'd1);
    c3_rsp_valid = 1'b0;
    repeat (2) step();
    chk("bad3_sticky", 64'(bad3), 64'd1);
    c3_rsp_valid = 1'b1; c3_rsp.tid = 8'd2;
    step();
    chk("n3_route2", 64'(rspv3_o), 64'(3'b100));
    c3_rsp_valid = 1'b0;

    // asynchronous reset while the buffer is full and stalled
    do_reset();
    drive(4'b0010, 1'b1);
    step();
    drive(4'b1111, 1'b0);
    step();
    chk("stall_full", 64'(c_valid), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", 64'(c_valid), 64'd0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    drive(4'b1111, 1'b1);
    #1;
    chk("post_rst_grant0", 64'(rdy_o), 64'(4'b0001));
    step();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(4'($urandom), ($urandom_range(0, 3) != 0));
      c_rsp_valid = 1'($urandom);
      c_rsp.data  = $urandom;
      c_rsp.tid   = 8'((i < 200) ? $urandom_range(0, 3) : $urandom_range(0, 5));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
